// File: rtl/block_check_sched_if.sv
// rtl/block_check_sched_if.sv - requester and checker signals of block_check_sched
interface block_check_sched_if;
  logic [1:0]  req_valid;
  logic [15:0] ch_in;
  logic [1:0]  ch_valid;
  logic [1:0]  ch_ready;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        verdict;
  logic        err;
  logic        chk_reset;
  logic [7:0]  chk_in;
  logic        chk_result;

  modport slave (
    input  req_valid, ch_in, ch_valid, chk_result,
    output ch_ready, grant, done, verdict, err, chk_reset, chk_in
  );

  modport master (
    output req_valid, ch_in, ch_valid, chk_result,
    input  ch_ready, grant, done, verdict, err, chk_reset, chk_in
  );
endinterface

// File: rtl/block_check_sched.sv
// rtl/block_check_sched.sv - two-requester session controller for a shared keyword block checker
// Buffers the owner's string, clears the checker, streams string plus two pads, returns the verdict.
module block_check_sched #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  block_check_sched_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_STREAM, S_SAMPLE} state_t;

  localparam logic [AW:0]   WR_ONE = 1;
  localparam logic [AW+1:0] RD_ONE = 1;
  localparam logic [AW+1:0] RD_TWO = 2;

  state_t      state, state_nx;
  logic [1:0]  grant_q, grant_nx, done_q;
  logic        last_q, last_nx;
  logic [AW:0] wr_ptr;
  logic [AW+1:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  chk_in_q, ch_sel, stream_ch;
  logic        clr_q, ovf, verdict_q, err_q;
  logic        v_sel, xfer, is_term, full, stream_end;

  assign ch_sel     = grant_q[1] ? bus.ch_in[15:8] : bus.ch_in[7:0];
  assign v_sel      = grant_q[1] ? bus.ch_valid[1] : bus.ch_valid[0];
  assign xfer       = (state == S_LOAD) && v_sel;
  assign is_term    = (ch_sel == 8'h00);
  // wr_ptr never exceeds DEPTH, so its top bit alone marks a full buffer
  assign full       = wr_ptr[AW];
  assign stream_end = (state == S_STREAM) && (rd_ptr == ({1'b0, wr_ptr} + RD_TWO));
  assign stream_ch  = ({1'b0, wr_ptr} > rd_ptr) ? mem[rd_ptr[AW-1:0]] : 8'h20;

  assign bus.ch_ready  = (state == S_LOAD) ? grant_q : 2'b00;
  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.verdict   = verdict_q;
  assign bus.err       = err_q;
  assign bus.chk_in    = chk_in_q;
  assign bus.chk_reset = ~reset | clr_q;

  always_comb begin
    state_nx = state;
    grant_nx = grant_q;
    last_nx  = last_q;
    case (state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          state_nx = S_LOAD;
          // on a tie the requester that was not granted last wins
          if (bus.req_valid == 2'b11) last_nx = ~last_q;
          else                        last_nx = bus.req_valid[1];
          grant_nx = last_nx ? 2'b10 : 2'b01;
        end
      end
      S_LOAD:   if (xfer && (is_term || full)) state_nx = S_CLEAR;
      S_CLEAR:  state_nx = S_STREAM;
      S_STREAM: if (stream_end) state_nx = S_SAMPLE;
      S_SAMPLE: begin
        state_nx = S_IDLE;
        grant_nx = 2'b00;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      chk_in_q  <= 8'h20;
      clr_q     <= 1'b0;
      ovf       <= 1'b0;
      done_q    <= 2'b00;
      verdict_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      grant_q  <= grant_nx;
      last_q   <= last_nx;
      clr_q    <= (state_nx == S_CLEAR);
      done_q   <= 2'b00;
      chk_in_q <= 8'h20;
      case (state)
        S_IDLE: wr_ptr <= '0;
        S_LOAD: begin
          rd_ptr <= '0;
          if (xfer && !is_term) begin
            if (full) ovf <= 1'b1;
            else      wr_ptr <= wr_ptr + WR_ONE;
          end
        end
        S_CLEAR, S_STREAM: begin
          rd_ptr <= rd_ptr + RD_ONE;
          if (state_nx == S_STREAM) chk_in_q <= stream_ch;
        end
        S_SAMPLE: begin
          verdict_q <= bus.chk_result & ~ovf;
          err_q     <= ovf;
          done_q    <= grant_q;
          ovf       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && !is_term && !full) mem[wr_ptr[AW-1:0]] <= ch_sel;
  end
endmodule

// File: tb/tb_block_check_sched.sv
// tb/tb_block_check_sched.sv - self-checking bench for block_check_sched
// Behavioural keyword checker drives chk_result; stream and verdict scoreboards compare DUT output.
module tb_block_check_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_check_sched_if bus();
  block_check_sched #(.DEPTH(16), .AW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  byte        exp_stream[$];
  int         exp_len[$];
  logic [3:0] exp_done[$];
  int         exp_lat[$];
  int         rem = 0;
  int         grant_cyc = 0;
  logic       prev_clr = 1'b0;
  logic [1:0] prev_grant = 2'b00;

  typedef struct {
    int    req;
    string s;
    bit    term;
    bit    gaps;
    bit    ev;
    bit    ee;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: timed out", name);
  endtask

  // keyword checker: case-insensitive begin/end nesting, words closed by spaces
  logic [39:0] word = '0;
  int          wlen = 0;
  int          depth = 0;
  logic        errl = 1'b0;
  logic [7:0]  lc;
  assign lc = (bus.chk_in >= "A" && bus.chk_in <= "Z") ? bus.chk_in + 8'h20 : bus.chk_in;
  always @(posedge clk) begin
    if (bus.chk_reset) begin
      word <= '0; wlen <= 0; depth <= 0; errl <= 1'b0;
    end else if (lc == 8'h20) begin
      if (wlen == 5 && word == "begin") depth <= depth + 1;
      else if (wlen == 3 && word[23:0] == "end") begin
        if (depth == 0) errl <= 1'b1;
        else depth <= depth - 1;
      end
      word <= '0; wlen <= 0;
    end else begin
      word <= {word[31:0], lc};
      wlen <= wlen + 1;
    end
  end
  assign bus.chk_result = !errl && (depth == 0);

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      rem = 0;
      prev_clr = 1'b0;
      prev_grant = 2'b00;
    end else begin
      if (prev_clr) begin
        check("chk_reset_width", {31'b0, bus.chk_reset}, 32'd0);
        if (exp_len.size() != 0) rem = exp_len.pop_front();
        else fail_now("unexpected_clear");
      end
      if (rem > 0) begin
        if (exp_stream.size() != 0) check("stream_byte", {24'b0, bus.chk_in}, {24'b0, exp_stream.pop_front()});
        else fail_now("stream_underflow");
        rem--;
      end
      if (bus.grant != 2'b00 && prev_grant == 2'b00) grant_cyc = cyc;
      if (bus.done != 2'b00) begin
        if (exp_done.size() != 0) begin
          int lat;
          check("done_verdict_err", {28'b0, bus.done, bus.verdict, bus.err}, {28'b0, exp_done.pop_front()});
          lat = exp_lat.pop_front();
          if (lat >= 0) check("latency", cyc - grant_cyc, lat);
        end else begin
          checks++;
          $display("FAIL unexpected_done: got %b expected 00", bus.done);
        end
      end
      prev_clr = bus.chk_reset;
      prev_grant = bus.grant;
    end
  end

  task automatic run_session(input int r, input string s, input bit term, input bit gaps,
                             input bit ev, input bit ee);
    int n, ls, i, to;
    bit bad, x;
    n  = s.len();
    ls = (n > 16) ? 16 : n;
    for (int k = 0; k < ls; k++) exp_stream.push_back(s[k]);
    exp_stream.push_back(8'h20);
    exp_stream.push_back(8'h20);
    exp_len.push_back(ls + 2);
    exp_done.push_back({(r == 1) ? 2'b10 : 2'b01, ev, ee});
    exp_lat.push_back(gaps ? -1 : (n + int'(term) + 1 + ls + 2 + 1));
    bus.req_valid[r] = 1'b1;
    to = 0;
    while (!bus.grant[r] && to < 100) begin @(negedge clk); to++; end
    if (!bus.grant[r]) begin fail_now("grant_wait"); bus.req_valid[r] = 1'b0; return; end
    check("grant_onehot", {30'b0, bus.grant}, (r == 1) ? 32'd2 : 32'd1);
    bus.req_valid[r] = 1'b0;
    i = 0; to = 0; bad = 1'b0;
    while (i < n + int'(term) && to < 1000) begin
      if (gaps && $urandom_range(0, 2) == 0) bus.ch_valid[r] = 1'b0;
      else begin
        bus.ch_valid[r] = 1'b1;
        bus.ch_in[8*r +: 8] = (i < n) ? s[i] : 8'h00;
      end
      if (bus.ch_ready[1-r]) bad = 1'b1;
      x = bus.ch_valid[r] && bus.ch_ready[r];
      @(negedge clk);
      to++;
      if (x) i++;
    end
    bus.ch_valid[r] = 1'b0;
    if (i < n + int'(term)) fail_now("load_wait");
    check("nonowner_ready", {31'b0, bad}, 32'd0);
  endtask

  task automatic wait_idle();
    int to = 0;
    while (exp_done.size() != 0 && to < 300) begin @(negedge clk); to++; end
    if (exp_done.size() != 0) begin
      fail_now("done_wait");
      exp_done.delete(); exp_lat.delete(); exp_stream.delete(); exp_len.delete();
    end
  endtask

  initial begin
    int to;
    vecs[0] = '{0, "begin end", 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1, "end begin", 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1, "BeGiN eNd", 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{0, "aaaaaaaaaaaaaaaaa", 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{0, "", 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{0, "beginx end", 1'b1, 1'b1, 1'b0, 1'b0};

    reset = 1'b0;
    bus.req_valid = 2'b11;
    bus.ch_in = '0;
    bus.ch_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_grant", {30'b0, bus.grant}, 32'd0);
    check("rst_done", {30'b0, bus.done}, 32'd0);
    check("rst_verdict", {31'b0, bus.verdict}, 32'd0);
    check("rst_err", {31'b0, bus.err}, 32'd0);
    check("rst_chk_in", {24'b0, bus.chk_in}, 32'h20);
    check("rst_chk_reset", {31'b0, bus.chk_reset}, 32'd1);
    check("rst_ch_ready", {30'b0, bus.ch_ready}, 32'd0);
    reset = 1'b1;

    // contention from reset: requester 0 first, requester 1 granted off the done[0] cycle
    run_session(0, "begin end", 1'b1, 1'b0, 1'b1, 1'b0);
    to = 0;
    while (bus.done != 2'b01 && to < 100) begin @(negedge clk); to++; end
    if (bus.done != 2'b01) fail_now("done0_wait");
    @(negedge clk);
    check("rr_second_grant", {30'b0, bus.grant}, 32'd2);
    run_session(1, "begin end", 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle();

    for (int v = 0; v < 6; v++) begin
      run_session(vecs[v].req, vecs[v].s, vecs[v].term, vecs[v].gaps, vecs[v].ev, vecs[v].ee);
      wait_idle();
    end

    // reset during STREAM abandons the session
    run_session(0, "begin end", 1'b1, 1'b0, 1'b1, 1'b0);
    to = 0;
    while (!bus.chk_reset && to < 100) begin @(negedge clk); to++; end
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    exp_done.delete(); exp_lat.delete(); exp_stream.delete(); exp_len.delete();
    #1;
    check("midrst_chk_reset", {31'b0, bus.chk_reset}, 32'd1);
    check("midrst_grant", {30'b0, bus.grant}, 32'd0);
    check("midrst_chk_in", {24'b0, bus.chk_in}, 32'h20);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      check("midrst_no_done", {30'b0, bus.done}, 32'd0);
    end
    run_session(0, "begin end", 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/block_check_sched.md
Name: block_check_sched

Overview:
Session controller that shares one keyword block checker between two text requesters. A granted requester's string is buffered in full, then streamed back-to-back into the checker, because the checker consumes one character every clock and has no stall input. The checker is cleared before each session, the string is padded with spaces to close the final word, and the pass/fail verdict is returned to the owning requester. The block sits between the requester ports and the checker instance.

Parameters:
DEPTH, 16, character buffer entries per session; power of two, at least 2.
AW, 4, buffer pointer width; equals log2(DEPTH).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
req_valid  input  2  bit i: requester i wants a session; level, sampled only in IDLE.
ch_in  input  16  requester i character on bits [8i+7:8i]; 8'h00 terminates the string.
ch_valid  input  2  bit i: ch_in slice i valid.
ch_ready  output  2  bit i: controller accepts requester i's character this cycle.
grant  output  2  one-hot session owner; 0 in IDLE.
done  output  2  one-cycle pulse to the owner at session end.
verdict  output  1  checker result for the finished session; valid while done != 0.
err  output  1  buffer overflow flag for the finished session; valid while done != 0.
chk_reset  output  1  active-high reset to the checker.
chk_in  output  8  character to the checker.
chk_result  input  1  checker result, combinational from checker state.

Behaviour:
- Reset (reset=0): state IDLE, grant=0, done=0, verdict=0, err=0, chk_in=8'h20, buffer counters 0, last-grant pointer=1.
  - chk_reset = ~reset | clr_q, so the checker is held in reset for as long as the controller is.
  - Reset mid-session abandons the session and produces no done pulse.
- States: IDLE, LOAD, CLEAR, STREAM, SAMPLE.
- IDLE:
  - If any req_valid bit is set, register grant and go to LOAD.
  - Round-robin: the requester other than last-grant wins on a tie; a lone requester wins outright.
  - Update last-grant when granting. Clear wr_ptr.
- LOAD:
  - ch_ready[g] = 1 for owner g only; ch_ready = 0 in every other state.
  - A transfer is ch_valid[g] & ch_ready[g]; the other requester's inputs are ignored.
  - Non-zero character with wr_ptr < DEPTH: write buf[wr_ptr], increment wr_ptr (width AW+1).
  - Terminator 8'h00: not stored; go to CLEAR.
  - Non-zero character with wr_ptr == DEPTH: accepted and dropped, ovf set, go to CLEAR.
  - Stalls (ch_valid=0) are unlimited.
- CLEAR: one cycle. clr_q=1, so chk_reset pulses high for exactly one cycle. rd_ptr=0. Go to STREAM.
- STREAM:
  - chk_in is registered. The cycle after CLEAR presents buf[0].
  - One character per cycle, buf[0] .. buf[wr_ptr-1], then exactly two 8'h20 pad characters, with no gaps.
  - Empty string (wr_ptr=0): only the two pads are streamed.
  - After the second pad has been presented for one clock edge, go to SAMPLE.
  - chk_in = 8'h20 in all other states.
- SAMPLE:
  - On the edge leaving SAMPLE: verdict <= chk_result & ~ovf, err <= ovf, done <= grant, grant <= 0, ovf <= 0; go to IDLE.
  - done is high exactly one cycle (the first IDLE cycle). A new grant may be issued in that same cycle.
- Latency: L stored characters, no stalls, terminator included → L+1 (LOAD) + 1 (CLEAR) + L+2 (STREAM) + 1 (SAMPLE); done visible on the next cycle.
- The two pads guarantee the final word is closed and the checker's S0 error latch is updated before sampling.
- Case handling and keyword semantics belong entirely to the checker. The controller passes bytes unmodified.
- req_valid deasserting during LOAD is ignored; the session ends only on terminator or overflow.

Test Plan:
- Requester 0 sends "begin end",8'h00 with valid every cycle → grant=2'b01; chk_reset one-cycle pulse; chk_in streams the 9 bytes then 20 20; done=2'b01 with verdict=1, err=0 after 9+1+1+11+1 cycles.
- Requester 1 sends "end begin",00 → done=2'b10, verdict=0. Then "BeGiN eNd",00 → verdict=1, confirming checker state was cleared between sessions.
- Both req_valid high from reset → requester 0 granted first; requester 1 granted in the cycle done[0] pulses; ch_ready never high for the non-owner.
- Requester 0 sends 17 non-zero 'a' characters with DEPTH=16 → the 17th is accepted, ovf set, no terminator needed; done=2'b01 with err=1, verdict=0.
- Requester 0 sends 00 only → chk_in = 20,20; verdict=1. "beginx end",00 with random ch_valid gaps → stream is gap-free; verdict=0.
- reset driven low during STREAM → chk_reset high immediately; grant=0; no done pulse. After release, a fresh "begin end",00 session gives verdict=1.
